// File: rtl/reg_bank_alu_seq.sv
// 16x32 register bank with a three-state command sequencer that feeds an external
// combinational ALU through registered operands and writes the result back to rd.
module reg_bank_alu_seq #(
    parameter int unsigned NREG = 16,
    parameter int unsigned AW   = 4,
    parameter int unsigned DW   = 32
) (
    input  logic          clk_i,
    input  logic          rst_ni,

    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [3:0]    cmd_op_i,
    input  logic [AW-1:0] cmd_rd_i,
    input  logic [AW-1:0] cmd_rs1_i,
    input  logic [AW-1:0] cmd_rs2_i,

    input  logic          ld_en_i,
    input  logic [AW-1:0] ld_addr_i,
    input  logic [DW-1:0] ld_data_i,

    output logic [DW-1:0] alu_a_o,
    output logic [DW-1:0] alu_b_o,
    output logic [3:0]    alu_op_o,
    input  logic [DW-1:0] alu_r_i,

    output logic          done_o,
    output logic [DW-1:0] result_o,

    input  logic [AW-1:0] dbg_addr_i,
    output logic [DW-1:0] dbg_data_o
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StWb
    } state_e;

    state_e        state_q;
    logic [DW-1:0] regs_q [NREG];
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [3:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] res_q;
    logic          done_q;
    logic          ready_q;

    logic          wb_en;
    logic          ld_take;

    assign wb_en   = (state_q == StWb);
    // Write-back owns its address this cycle; a colliding external load is dropped.
    assign ld_take = ld_en_i && !(wb_en && (ld_addr_i == rd_q));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            if (ld_take) begin
                regs_q[ld_addr_i] <= ld_data_i;
            end
            if (wb_en) begin
                regs_q[rd_q] <= res_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        // Operands sample the bank before this edge's writes land.
                        a_q     <= regs_q[cmd_rs1_i];
                        b_q     <= regs_q[cmd_rs2_i];
                        op_q    <= cmd_op_i;
                        rd_q    <= cmd_rd_i;
                        ready_q <= 1'b0;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    res_q   <= alu_r_i;
                    done_q  <= 1'b1;
                    state_q <= StWb;
                end
                StWb: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign cmd_ready_o = ready_q;
    assign alu_a_o     = a_q;
    assign alu_b_o     = b_q;
    assign alu_op_o    = op_q;
    assign done_o      = done_q;
    assign result_o    = res_q;
    assign dbg_data_o  = regs_q[dbg_addr_i];

endmodule

// File: tb/tb_reg_bank_alu_seq.sv
// Directed bench for reg_bank_alu_seq with a two-function ALU model (op0 add, op1 sub).
module tb_reg_bank_alu_seq;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [3:0]  cmd_rd;
    logic [3:0]  cmd_rs1;
    logic [3:0]  cmd_rs2;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [31:0] ld_data;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_r;
    logic        done;
    logic [31:0] result;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int pass_cnt;
    int total_cnt;

    reg_bank_alu_seq #(
        .NREG(16),
        .AW  (4),
        .DW  (32)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .cmd_valid_i(cmd_valid),
        .cmd_ready_o(cmd_ready),
        .cmd_op_i   (cmd_op),
        .cmd_rd_i   (cmd_rd),
        .cmd_rs1_i  (cmd_rs1),
        .cmd_rs2_i  (cmd_rs2),
        .ld_en_i    (ld_en),
        .ld_addr_i  (ld_addr),
        .ld_data_i  (ld_data),
        .alu_a_o    (alu_a),
        .alu_b_o    (alu_b),
        .alu_op_o   (alu_op),
        .alu_r_i    (alu_r),
        .done_o     (done),
        .result_o   (result),
        .dbg_addr_i (dbg_addr),
        .dbg_data_o (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        alu_r = alu_a ^ alu_b;
        if (alu_op == 4'd0) alu_r = alu_a + alu_b;
        else if (alu_op == 4'd1) alu_r = alu_a - alu_b;
    end

    task automatic load_reg(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic drive_cmd(input logic [3:0] op, input logic [3:0] rd,
                             input logic [3:0] rs1, input logic [3:0] rs2);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            total_cnt++;
            if (dbg_data !== 32'd0) $display("FAIL reset_reg%0d got %h want 0", i, dbg_data);
            else pass_cnt++;
        end
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done);
        else pass_cnt++;
        total_cnt++;
        if ({alu_a, alu_b, alu_op} !== 68'd0)
            $display("FAIL reset_alu got %h/%h/%h want 0", alu_a, alu_b, alu_op);
        else pass_cnt++;
    endtask

    task automatic test_add;
        load_reg(4'd1, 32'd5);
        load_reg(4'd2, 32'd3);
        drive_cmd(4'd0, 4'd3, 4'd1, 4'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        total_cnt++;
        if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 4'd0)
            $display("FAIL add_operands got %0d/%0d/%0d want 5/3/0", alu_a, alu_b, alu_op);
        else pass_cnt++;
        total_cnt++;
        if (cmd_ready !== 1'b0 || done !== 1'b0)
            $display("FAIL add_exec_flags got rdy=%b done=%b want 0/0", cmd_ready, done);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b1 || result !== 32'd8)
            $display("FAIL add_wb got done=%b res=%0d want 1/8", done, result);
        else pass_cnt++;
        dbg_addr = 4'd3;
        #1;
        total_cnt++;
        if (dbg_data !== 32'd0) $display("FAIL add_prewrite got %0d want 0", dbg_data);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (dbg_data !== 32'd8) $display("FAIL add_r3 got %0d want 8", dbg_data);
        else pass_cnt++;
        total_cnt++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || result !== 32'd8 || alu_a !== 32'd5)
            $display("FAIL add_idle_hold got done=%b rdy=%b res=%0d a=%0d want 0/1/8/5",
                     done, cmd_ready, result, alu_a);
        else pass_cnt++;
    endtask

    task automatic test_sub;
        drive_cmd(4'd1, 4'd4, 4'd2, 4'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (done !== 1'b1 || result !== 32'hFFFF_FFFE)
            $display("FAIL sub_wb got done=%b res=%h want 1/fffffffe", done, result);
        else pass_cnt++;
        @(negedge clk);
        dbg_addr = 4'd4;
        #1;
        total_cnt++;
        if (dbg_data !== 32'hFFFF_FFFE) $display("FAIL sub_r4 got %h want fffffffe", dbg_data);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        drive_cmd(4'd0, 4'd3, 4'd1, 4'd2);
        @(negedge clk);
        total_cnt++;
        if (cmd_ready !== 1'b0) $display("FAIL b2b_busy1 got %b want 0", cmd_ready);
        else pass_cnt++;
        drive_cmd(4'd0, 4'd5, 4'd3, 4'd3);
        @(negedge clk);
        total_cnt++;
        if (cmd_ready !== 1'b0 || alu_a !== 32'd5)
            $display("FAIL b2b_busy2 got rdy=%b a=%0d want 0/5", cmd_ready, alu_a);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (cmd_ready !== 1'b1) $display("FAIL b2b_ready got %b want 1", cmd_ready);
        else pass_cnt++;
        @(negedge clk);
        cmd_valid = 1'b0;
        total_cnt++;
        if (cmd_ready !== 1'b0 || alu_a !== 32'd8 || alu_b !== 32'd8)
            $display("FAIL b2b_accept2 got rdy=%b a=%0d b=%0d want 0/8/8", cmd_ready, alu_a, alu_b);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        dbg_addr = 4'd5;
        #1;
        total_cnt++;
        if (dbg_data !== 32'd16) $display("FAIL b2b_r5 got %0d want 16", dbg_data);
        else pass_cnt++;
    endtask

    task automatic test_collision;
        drive_cmd(4'd0, 4'd3, 4'd1, 4'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 4'd3; ld_data = 32'hAAAA;
        @(negedge clk);
        ld_en = 1'b0;
        dbg_addr = 4'd3;
        #1;
        total_cnt++;
        if (dbg_data !== 32'd8) $display("FAIL coll_same got %h want 8", dbg_data);
        else pass_cnt++;
        drive_cmd(4'd1, 4'd7, 4'd1, 4'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 4'd6; ld_data = 32'hAAAA;
        @(negedge clk);
        ld_en = 1'b0;
        dbg_addr = 4'd7;
        #1;
        total_cnt++;
        if (dbg_data !== 32'd2) $display("FAIL coll_r7 got %h want 2", dbg_data);
        else pass_cnt++;
        dbg_addr = 4'd6;
        #1;
        total_cnt++;
        if (dbg_data !== 32'hAAAA) $display("FAIL coll_r6 got %h want aaaa", dbg_data);
        else pass_cnt++;
    endtask

    task automatic test_read_old;
        drive_cmd(4'd0, 4'd9, 4'd1, 4'd2);
        ld_en = 1'b1; ld_addr = 4'd1; ld_data = 32'd100;
        @(negedge clk);
        cmd_valid = 1'b0;
        ld_addr = 4'd2; ld_data = 32'd50;
        total_cnt++;
        if (alu_a !== 32'd5) $display("FAIL rdold_a got %0d want 5", alu_a);
        else pass_cnt++;
        @(negedge clk);
        ld_en = 1'b0;
        total_cnt++;
        if (alu_b !== 32'd3) $display("FAIL rdold_b got %0d want 3", alu_b);
        else pass_cnt++;
        @(negedge clk);
        dbg_addr = 4'd9;
        #1;
        total_cnt++;
        if (dbg_data !== 32'd8) $display("FAIL rdold_r9 got %0d want 8", dbg_data);
        else pass_cnt++;
        dbg_addr = 4'd1;
        #1;
        total_cnt++;
        if (dbg_data !== 32'd100) $display("FAIL rdold_r1 got %0d want 100", dbg_data);
        else pass_cnt++;
        dbg_addr = 4'd2;
        #1;
        total_cnt++;
        if (dbg_data !== 32'd50) $display("FAIL rdold_r2 got %0d want 50", dbg_data);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid;
        int done_seen;
        done_seen = 0;
        drive_cmd(4'd0, 4'd8, 4'd1, 4'd2);
        @(negedge clk);
        cmd_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || alu_a !== 32'd0)
            $display("FAIL rstmid_flags got done=%b rdy=%b a=%0d want 0/1/0",
                     done, cmd_ready, alu_a);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        total_cnt++;
        if (done_seen != 0) $display("FAIL rstmid_done got %0d pulses want 0", done_seen);
        else pass_cnt++;
        dbg_addr = 4'd8;
        #1;
        total_cnt++;
        if (dbg_data !== 32'd0) $display("FAIL rstmid_r8 got %0d want 0", dbg_data);
        else pass_cnt++;
        dbg_addr = 4'd1;
        #1;
        total_cnt++;
        if (dbg_data !== 32'd0 || cmd_ready !== 1'b1)
            $display("FAIL rstmid_idle got r1=%0d rdy=%b want 0/1", dbg_data, cmd_ready);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_rd    = '0;
        cmd_rs1   = '0;
        cmd_rs2   = '0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        dbg_addr  = '0;
        @(negedge clk);
        test_reset;
        test_add;
        test_sub;
        test_back_to_back;
        test_collision;
        test_read_old;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
